memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Parametrised RAM arbiter and coherence-free bus controller for a `CPUS`-core system. It sits between the per-core instruction/data cache ports and the single-ported RAM. It grants one cache request at a time, holding the grant until the RAM completes it. Arbitration is round-robin across cores; within a core, data requests take priority over instruction requests. Its registered grant state machine replaces purely combinational steering, so a transfer cannot be stolen mid-access.

## Interface
Parameters:
- `CPUS`, 2: number of cores (1..8); index width `CW = max(1,$clog2(CPUS))`.
- `DPRIO`, 1: 1 = data over instruction within a core; 0 = instruction over data.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset; synchronous, active-high.
- `iREN` in [CPUS]: instruction read request per core.
- `dREN` in [CPUS]: data read request per core.
- `dWEN` in [CPUS]: data write request per core.
- `iaddr` in [CPUS] word_t: instruction address.
- `daddr` in [CPUS] word_t: data address.
- `dstore` in [CPUS] word_t: write data.
- `iwait` out [CPUS]: 1 = instruction request not complete.
- `dwait` out [CPUS]: 1 = data request not complete.
- `iload` out [CPUS] word_t: instruction read data.
- `dload` out [CPUS] word_t: data read data.
- `ramaddr` out word_t: RAM address.
- `ramstore` out word_t: RAM write data.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramload` in word_t: RAM read data.
- `ramstate` in ramstate_t: FREE / BUSY / ACCESS / ERROR.

## Operation
- States: `IDLE`, `XFER`.
- `IDLE`:
  - Scan cores starting at `rr_ptr`, wrapping modulo `CPUS`.
  - The first core with any request wins.
  - The request type chosen within that core follows `DPRIO`.
  - `dWEN` with `dREN` both high counts as a write.
  - Register `gnt_cpu` and `gnt_type` (I, DR, DW), then go to `XFER`.
  - No request: stay in `IDLE`.
  - RAM enables are 0 and all waits are 1 in `IDLE`.
- `XFER`:
  - Drive `ramaddr` combinationally from the granted source: `daddr[gnt_cpu]` for DR/DW, `iaddr[gnt_cpu]` for I.
  - Drive `ramstore` from `dstore[gnt_cpu]`.
  - Assert `ramWEN` for DW, `ramREN` for I/DR.
  - When `ramstate==ACCESS`:
    - Drop the granted wait for that cycle only.
    - Go to `IDLE`.
    - Set `rr_ptr = gnt_cpu+1`, wrapping to 0 at `CPUS`.
- Abort: if the granted request line deasserts in `XFER`, go to `IDLE` with no wait drop; `rr_ptr` is unchanged.
- `ramstate` BUSY/FREE: remain in `XFER` with waits high.
- `ramstate` ERROR: remain in `XFER` with waits high, until abort or reset.
- Read data:
  - `iload[k]` and `dload[k]` always equal `ramload` for every k.
  - The wait line qualifies validity.
- Non-granted requesters always see their wait at 1.

## Timing
- Reset:
  - State `IDLE`, `rr_ptr=0`, `gnt_cpu=0`, `gnt_type=I`.
  - While `RST` is high, outputs are forced: `ramREN=ramWEN=0`, `ramaddr=ramstore=0`, all waits 1.
- Reset mid-`XFER`:
  - RAM enables drop in the same cycle.
  - No wait drop occurs.
  - State is `IDLE` after the edge.
- Latency:
  - Request seen at edge N.
  - RAM enables are driven from cycle N+1.
  - Wait drops in the first cycle with `ramstate==ACCESS`, at cycle N+1 at the earliest.
  - Back-to-back grants are separated by one `IDLE` cycle.
- A single core requesting continuously is granted every other cycle at minimum, with no starvation of others.
- Any requester waits at most `CPUS` grants before service.

## Structure
- `cpu_types_pkg` holds `word_t` and `ramstate_t`.
- Add a `gnt_t` enum (I, DR, DW) and an `arb_state_t` enum (IDLE, XFER) to `cpu_types_pkg`.
- Sub-module `rr_arbiter`:
  - Parametrised by `N`.
  - Inputs: request vector, `ptr`.
  - Outputs: one-hot grant, encoded index, any-valid.
  - Purely combinational.

## Test plan
- CPUS=2, core0 `dREN` on `daddr=0x40`, RAM answers ACCESS after 2 BUSY cycles:
  - `ramREN=1`, `ramaddr=0x40` from cycle 1.
  - `dwait[0]` is 0 only at cycle 3.
  - `dload[0]=ramload`.
- Core0 `iREN` and `dWEN` (`daddr=0x80`, `dstore=0xDEADBEEF`) together, `DPRIO=1`:
  - Write first, with `ramWEN=1` and `ramstore=0xDEADBEEF`.
  - Instruction fetch serviced after one `IDLE` cycle.
- Both cores requesting continuously, RAM always ACCESS:
  - Grants alternate 0,1,0,1.
  - Each wait drops every 4 cycles.
- Core1 aborts (`dREN` low) during BUSY:
  - Return to `IDLE` with no `dwait[1]` drop.
  - `rr_ptr` unchanged.
  - Core1 is regranted on the next request.
- `RST` pulsed in `XFER` with ERROR:
  - Enables drop that cycle.
  - All waits 1.
  - Next request granted from `rr_ptr=0`.
- CPUS=4, requests from cores 1 and 3 with `rr_ptr=2`: core 3 is granted before core 1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM bus types.
// Also carries the arbiter's grant-type and FSM state enums.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    I,
    DR,
    DW
  } gnt_t;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans from i_ptr upward, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);
  logic [W-1:0] w_c;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_c     = '0;
    for (int k = 0; k < N; k++) begin
      w_c = W'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_c]) begin
        o_valid    = 1'b1;
        o_idx      = w_c;
        o_gnt[w_c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/memory_arbiter.sv
// Round-robin RAM arbiter for CPUS cores.
// A grant is held until the RAM reports ACCESS or the requester aborts.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS  = 2,
  parameter bit DPRIO = 1'b1,
  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]     iaddr,
  input  word_t [CPUS-1:0]     daddr,
  input  word_t [CPUS-1:0]     dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output word_t [CPUS-1:0]     iload,
  output word_t [CPUS-1:0]     dload,
  output word_t                ramaddr,
  output word_t                ramstore,
  output logic                 ramREN,
  output logic                 ramWEN,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);
  arb_state_t    r_state, w_next;
  logic [CW-1:0] r_rr_ptr, r_gnt_cpu;
  gnt_t          r_gnt_type, w_type;

  logic [CPUS-1:0] w_req_any, w_gnt_oh;
  logic [CW-1:0]   w_win, w_ptr_inc;
  logic            w_any, w_wi, w_wr, w_ww;
  logic            w_line, w_done;

  assign w_req_any = iREN | dREN | dWEN;

  rr_arbiter #(.N(CPUS)) u_rr (
    .i_req   (w_req_any),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_gnt_oh),
    .o_idx   (w_win),
    .o_valid (w_any)
  );

  assign w_wi = |(iREN & w_gnt_oh);
  assign w_wr = |(dREN & w_gnt_oh);
  assign w_ww = |(dWEN & w_gnt_oh);

  // A write with a simultaneous read counts as a write.
  always_comb begin
    w_type = I;
    if (DPRIO) begin
      if (w_ww)      w_type = DW;
      else if (w_wr) w_type = DR;
      else           w_type = I;
    end else begin
      if (w_wi)      w_type = I;
      else if (w_ww) w_type = DW;
      else           w_type = DR;
    end
  end

  always_comb begin
    unique case (r_gnt_type)
      I:       w_line = iREN[r_gnt_cpu];
      DR:      w_line = dREN[r_gnt_cpu];
      default: w_line = dWEN[r_gnt_cpu];
    endcase
  end

  assign w_done = (r_state == XFER) && w_line
                  && (ramstate == ACCESS);

  assign w_ptr_inc = (r_gnt_cpu == CW'(CPUS - 1))
                     ? '0 : r_gnt_cpu + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_gnt_cpu  <= '0;
      r_gnt_type <= I;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_gnt_cpu  <= w_win;
        r_gnt_type <= w_type;
      end
      if (w_done) r_rr_ptr <= w_ptr_inc;
    end
  end

  always_comb begin
    w_next   = r_state;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    iwait    = '1;
    dwait    = '1;
    unique case (r_state)
      IDLE: begin
        if (w_any) w_next = XFER;
      end
      XFER: begin
        ramaddr  = (r_gnt_type == I) ? iaddr[r_gnt_cpu]
                                     : daddr[r_gnt_cpu];
        ramstore = dstore[r_gnt_cpu];
        ramREN   = (r_gnt_type != DW);
        ramWEN   = (r_gnt_type == DW);
        if (!w_line) begin
          w_next = IDLE;
        end else if (ramstate == ACCESS) begin
          w_next = IDLE;
          if (r_gnt_type == I) iwait[r_gnt_cpu] = 1'b0;
          else                 dwait[r_gnt_cpu] = 1'b0;
        end
      end
      default: w_next = IDLE;
    endcase
    // Reset overrides everything, including a grant in flight.
    if (RST) begin
      ramaddr  = '0;
      ramstore = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      iwait    = '1;
      dwait    = '1;
    end
  end

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter.
// Directed scenarios plus random traffic against a transaction-level model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int NC = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NC-1:0]   iREN, dREN, dWEN;
  word_t [NC-1:0]  iaddr, daddr, dstore;
  logic [NC-1:0]   iwait, dwait;
  word_t [NC-1:0]  iload, dload;
  word_t           ramaddr, ramstore, ramload;
  logic            ramREN, ramWEN;
  ramstate_t       ramstate;

  logic [3:0]      dREN4;
  word_t [3:0]     daddr4;
  logic [3:0]      iwait4, dwait4;
  word_t [3:0]     iload4, dload4;
  word_t           ramaddr4, ramstore4;
  logic            ramREN4, ramWEN4;
  ramstate_t       rs4;

  int errs = 0;
  int checks = 0;

  bit m_busy;
  int m_cpu, m_type, m_ptr;

  always #5 CLK = ~CLK;

  memory_arbiter #(.CPUS(NC), .DPRIO(1'b1)) u_dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate)
  );

  memory_arbiter #(.CPUS(4), .DPRIO(1'b1)) u_dut4 (
    .CLK(CLK), .RST(RST),
    .iREN(4'b0), .dREN(dREN4), .dWEN(4'b0),
    .iaddr('0), .daddr(daddr4), .dstore('0),
    .iwait(iwait4), .dwait(dwait4),
    .iload(iload4), .dload(dload4),
    .ramaddr(ramaddr4), .ramstore(ramstore4),
    .ramREN(ramREN4), .ramWEN(ramWEN4),
    .ramload(ramload), .ramstate(rs4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already applied at the negedge.
  task automatic step();
    logic          e_ren, e_wen, line;
    logic [NC-1:0] e_iw, e_dw;
    word_t         e_addr, e_st;
    #1;
    e_ren = 1'b0; e_wen = 1'b0;
    e_iw = '1; e_dw = '1;
    e_addr = '0; e_st = '0;
    line = 1'b0;
    if (m_busy)
      line = (m_type == 0) ? iREN[m_cpu] :
             (m_type == 1) ? dREN[m_cpu] : dWEN[m_cpu];
    if (!RST && m_busy) begin
      e_addr = (m_type == 0) ? iaddr[m_cpu] : daddr[m_cpu];
      e_st   = dstore[m_cpu];
      e_ren  = (m_type != 2);
      e_wen  = (m_type == 2);
      if (line && ramstate == ACCESS) begin
        if (m_type == 0) e_iw[m_cpu] = 1'b0;
        else             e_dw[m_cpu] = 1'b0;
      end
    end
    chk("ramREN", 32'(ramREN), 32'(e_ren));
    chk("ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("iwait", 32'(iwait), 32'(e_iw));
    chk("dwait", 32'(dwait), 32'(e_dw));
    chk("dload1", dload[1], ramload);
    chk("iload0", iload[0], ramload);
    if (RST || m_busy) begin
      chk("ramaddr", ramaddr, e_addr);
      chk("ramstore", ramstore, e_st);
    end
    if (RST) begin
      m_busy = 0; m_ptr = 0;
    end else if (!m_busy) begin
      for (int o = 0; o < NC; o++) begin
        int k;
        k = (m_ptr + o) % NC;
        if (!m_busy && (iREN[k] || dREN[k] || dWEN[k])) begin
          m_busy = 1;
          m_cpu  = k;
          m_type = dWEN[k] ? 2 : dREN[k] ? 1 : 0;
        end
      end
    end else if (!line) begin
      m_busy = 0;
    end else if (ramstate == ACCESS) begin
      m_busy = 0;
      m_ptr  = (m_cpu + 1) % NC;
    end
    @(negedge CLK);
  endtask

  initial begin
    m_busy = 0; m_cpu = 0; m_type = 0; m_ptr = 0;
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = 32'h1234_5678; ramstate = FREE;
    dREN4 = '0; rs4 = FREE;
    for (int k = 0; k < 4; k++) daddr4[k] = 32'h100 * k + 32'h4;
    @(negedge CLK);
    step(); step();
    RST = 1'b0;

    // Data read, two BUSY cycles then ACCESS.
    dREN[0] = 1'b1; daddr[0] = 32'h40; ramstate = BUSY;
    step(); step(); step();
    ramstate = ACCESS; ramload = 32'hCAFE_0001;
    step();
    dREN[0] = 1'b0;
    step();

    // Write and fetch together: write first.
    iREN[0] = 1'b1; dWEN[0] = 1'b1; iaddr[0] = 32'h1000;
    daddr[0] = 32'h80; dstore[0] = 32'hDEAD_BEEF;
    step(); step();
    dWEN[0] = 1'b0;
    step(); step();
    iREN[0] = 1'b0;
    step();

    // Both cores continuous, RAM always ready.
    dREN = 2'b11; daddr[1] = 32'h44;
    for (int n = 0; n < 8; n++) step();
    dREN = '0;
    step();

    // Core1 aborts during BUSY, then is regranted.
    dREN[1] = 1'b1; ramstate = BUSY;
    step(); step();
    dREN[1] = 1'b0;
    step(); step();
    dREN[1] = 1'b1; ramstate = ACCESS;
    step(); step();
    dREN[1] = 1'b0;
    step();

    // Reset during an ERROR-stalled grant.
    dREN[0] = 1'b1; ramstate = ERROR;
    step(); step();
    RST = 1'b1;
    step();
    RST = 1'b0; dREN = 2'b11; ramstate = ACCESS;
    step(); step(); step(); step();
    dREN = '0;
    step();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NC; k++) begin
        if ($urandom_range(0, 3) == 0) iREN[k] = ~iREN[k];
        if ($urandom_range(0, 3) == 0) dREN[k] = ~dREN[k];
        if ($urandom_range(0, 5) == 0) dWEN[k] = ~dWEN[k];
        iaddr[k]  = $urandom;
        daddr[k]  = $urandom;
        dstore[k] = $urandom;
      end
      ramload  = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      RST      = ($urandom_range(0, 49) == 0);
      step();
    end
    RST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
    step();

    // Four cores: with pointer at 2, core 3 beats core 1.
    dREN4 = 4'b0010; rs4 = ACCESS;
    @(negedge CLK); #1;
    chk("c4_first", ramaddr4, daddr4[1]);
    dREN4 = 4'b1010;
    @(negedge CLK);
    @(negedge CLK); #1;
    chk("c4_core3", ramaddr4, daddr4[3]);
    chk("c4_ren", 32'(ramREN4), 32'd1);
    @(negedge CLK);
    @(negedge CLK); #1;
    chk("c4_core1", ramaddr4, daddr4[1]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
